// File: rtl/tpo_ctrl.sv
// Sequencing controller for the three-mode TPO fractional-delay interpolator.
// Optional skip statistics counter enabled by defining TPO_CTRL_STATS_EN.
module tpo_ctrl #(
  parameter int ACC_W  = 10,
  parameter int FILL_N = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [ACC_W-1:0] step,
  input  logic             in_valid,
  output logic             tpo_en,
  output logic [1:0]       tpo_mode,
  output logic             out_valid,
  output logic             skip,
`ifdef TPO_CTRL_STATS_EN
  output logic [15:0]      skip_cnt,
`endif
  output logic             busy
);

  localparam int FC_W = $clog2(FILL_N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [ACC_W-1:0] acc, acc_d;
  logic [FC_W-1:0]  fill_cnt, fill_d;
  logic             ov_d, skip_d;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [4:0]       p;
  logic [1:0]       run_mode;
  logic             fill_last;

  assign sum       = {1'b0, acc} + {1'b0, step};
  assign carry     = sum[ACC_W];
  assign p         = acc[ACC_W-1 -: 5];
  assign fill_last = (fill_cnt == FC_W'(FILL_N - 1));

  // mu selection from the current phase, before this sample's update
  always_comb begin
    run_mode = 2'd2;
    unique case (1'b1)
      (p <= 5'd5):                 run_mode = 2'd0;
      (p >= 5'd6 && p <= 5'd12):   run_mode = 2'd1;
      (p >= 5'd13):                run_mode = 2'd2;
      default:                     run_mode = 2'd2;
    endcase
  end

  always_comb begin
    state_d  = state;
    acc_d    = acc;
    fill_d   = fill_cnt;
    ov_d     = 1'b0;
    skip_d   = 1'b0;
    tpo_en   = 1'b0;
    tpo_mode = 2'd2;
    unique case (state)
      IDLE: begin
        if (start) state_d = FILL;
      end
      FILL: begin
        if (in_valid) begin
          tpo_en = 1'b1;
          if (fill_last) begin
            fill_d  = '0;
            state_d = RUN;
          end else begin
            fill_d = fill_cnt + 1'b1;
          end
        end
      end
      RUN: begin
        tpo_mode = run_mode;
        if (in_valid) begin
          acc_d  = sum[ACC_W-1:0];
          tpo_en = ~carry;
          ov_d   = ~carry;
          skip_d = carry;
        end
      end
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d = IDLE;
      acc_d   = '0;
      fill_d  = '0;
      tpo_en  = 1'b0;
      ov_d    = 1'b0;
      skip_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      skip      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      fill_cnt  <= fill_d;
      out_valid <= ov_d;
      skip      <= skip_d;
      busy      <= (state_d != IDLE);
    end
  end

`ifdef TPO_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skip_cnt <= '0;
    end else if (state == IDLE && start && !stop) begin
      skip_cnt <= '0;
    end else if (skip_d && skip_cnt != 16'hFFFF) begin
      skip_cnt <= skip_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tpo_ctrl.sv
// Directed table-driven bench for tpo_ctrl (ACC_W=10, FILL_N=2).
// Skip counter checks are active when TPO_CTRL_STATS_EN is defined.
module tb_tpo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, in_valid;
  logic [9:0] step;
  logic       tpo_en, out_valid, skip, busy;
  logic [1:0] tpo_mode;
`ifdef TPO_CTRL_STATS_EN
  logic [15:0] skip_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tpo_ctrl #(.ACC_W(10), .FILL_N(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .step(step),
    .in_valid(in_valid),
    .tpo_en(tpo_en),
    .tpo_mode(tpo_mode),
    .out_valid(out_valid),
    .skip(skip),
`ifdef TPO_CTRL_STATS_EN
    .skip_cnt(skip_cnt),
`endif
    .busy(busy)
  );

  typedef struct {
    bit         st;
    bit         sp;
    bit         iv;
    logic [9:0] stp;
    bit         en;
    logic [1:0] md;
    bit         ov;
    bit         sk;
    bit         bs;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(bit st, bit sp, bit iv, int stp,
                              bit en, int md, bit ov, bit sk, bit bs);
    vec_t v;
    v.st  = st;
    v.sp  = sp;
    v.iv  = iv;
    v.stp = stp[9:0];
    v.en  = en;
    v.md  = md[1:0];
    v.ov  = ov;
    v.sk  = sk;
    v.bs  = bs;
    return v;
  endfunction

  task automatic drive(input bit rs, input bit st, input bit sp,
                       input bit iv, input int stp);
    @(negedge clk);
    rst_n    = rs;
    start    = st;
    stop     = sp;
    in_valid = iv;
    step     = stp[9:0];
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  initial begin
    //          st sp iv step  en md ov sk bs
    tbl[0]  = mk(0, 0, 1, 0,    0, 2, 0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 0,    0, 2, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0,    1, 2, 0, 0, 1);
    tbl[3]  = mk(0, 0, 1, 0,    1, 2, 0, 0, 1);
    tbl[4]  = mk(0, 0, 1, 0,    1, 0, 0, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0,    0, 0, 1, 0, 1);
    tbl[6]  = mk(0, 0, 1, 200,  1, 0, 0, 0, 1);
    tbl[7]  = mk(0, 0, 1, 300,  1, 1, 1, 0, 1);
    tbl[8]  = mk(0, 0, 1, 600,  0, 2, 1, 0, 1);
    tbl[9]  = mk(0, 0, 1, 0,    1, 0, 0, 1, 1);
    tbl[10] = mk(1, 1, 1, 0,    0, 0, 1, 0, 1);
    tbl[11] = mk(0, 0, 1, 0,    0, 2, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 0,    0, 2, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0,    0, 2, 0, 0, 1);
    tbl[14] = mk(0, 0, 1, 0,    1, 2, 0, 0, 1);
    tbl[15] = mk(0, 0, 1, 0,    1, 2, 0, 0, 1);
    tbl[16] = mk(0, 0, 1, 1023, 1, 0, 0, 0, 1);
    tbl[17] = mk(0, 0, 1, 1023, 0, 2, 1, 0, 1);
    tbl[18] = mk(0, 0, 1, 1023, 0, 2, 0, 1, 1);
    tbl[19] = mk(0, 0, 0, 0,    0, 2, 0, 1, 1);
    tbl[20] = mk(0, 1, 0, 0,    0, 2, 0, 0, 1);
    tbl[21] = mk(0, 0, 0, 0,    0, 2, 0, 0, 0);

    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    in_valid = 1'b0; step = '0;
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);

    for (int i = 0; i < 22; i++) begin
      drive(1, tbl[i].st, tbl[i].sp, tbl[i].iv, int'(tbl[i].stp));
      chk($sformatf("v%0d_en", i), int'(tpo_en), int'(tbl[i].en));
      chk($sformatf("v%0d_mode", i), int'(tpo_mode), int'(tbl[i].md));
      chk($sformatf("v%0d_ov", i), int'(out_valid), int'(tbl[i].ov));
      chk($sformatf("v%0d_skip", i), int'(skip), int'(tbl[i].sk));
      chk($sformatf("v%0d_busy", i), int'(busy), int'(tbl[i].bs));
    end

    // mode sweep: step of 1/32, wrap on the 32nd RUN sample
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    for (int i = 0; i < 32; i++) begin
      int em;
      em = (i <= 5) ? 0 : (i <= 12) ? 1 : 2;
      drive(1, 0, 0, 1, 32);
      chk($sformatf("sw%0d_mode", i), int'(tpo_mode), em);
      chk($sformatf("sw%0d_en", i), int'(tpo_en), (i != 31) ? 1 : 0);
      chk($sformatf("sw%0d_ov", i), int'(out_valid), (i != 0) ? 1 : 0);
      chk($sformatf("sw%0d_skip", i), int'(skip), 0);
    end
    drive(1, 0, 0, 0, 0);
    chk("sw_wrap_skip", int'(skip), 1);
    chk("sw_wrap_ov", int'(out_valid), 0);

    // reset in RUN clears registered outputs
    drive(1, 0, 0, 1, 0);
    chk("mr_en", int'(tpo_en), 1);
    drive(0, 0, 0, 1, 0);
    chk("mr_ov_pre", int'(out_valid), 1);
    drive(1, 0, 0, 1, 0);
    chk("mr_ov", int'(out_valid), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_en0", int'(tpo_en), 0);
    chk("mr_mode", int'(tpo_mode), 2);

    // half-cycle step: every second RUN sample wraps
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 1, 512);
      chk($sformatf("h%0d_en", i), int'(tpo_en), (i % 2 == 0) ? 1 : 0);
    end
    drive(1, 0, 0, 0, 0);
    chk("h_skip", int'(skip), 1);
`ifdef TPO_CTRL_STATS_EN
    chk("st_cnt5", int'(skip_cnt), 5);
`endif
    drive(1, 0, 1, 0, 0);
`ifdef TPO_CTRL_STATS_EN
    drive(1, 0, 0, 0, 0);
    chk("st_hold", int'(skip_cnt), 5);
`endif
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("st_busy", int'(busy), 1);
`ifdef TPO_CTRL_STATS_EN
    chk("st_clr", int'(skip_cnt), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tpo_ctrl.md
# tpo_ctrl

Sequencing controller for the carrier-offset fractional-delay interpolator (three-mode TPO datapath, mu ≈ 3/32, 9/32, 16/32). It tracks the accumulated sampling-phase offset in a fractional accumulator and drives the interpolator's `en`/`mode` pins per input sample. It primes the interpolator's two-sample pipeline, drops one sample on every phase wrap, and flags which interpolator outputs are valid. It sits between the ADC sample stream and the interpolator inside the CarrierOffset chain.

## Interface
- `ACC_W`, 10: phase accumulator width, all fractional bits, unsigned; top 5 bits give phase in 1/32 units.
- `FILL_N`, 2: accepted samples spent priming the interpolator before outputs are flagged valid.

- `clk`, in, 1: single clock, all logic on rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: single-cycle pulse; leave IDLE.
- `stop`, in, 1: single-cycle pulse; abort to IDLE.
- `step`, in, ACC_W: phase increment per accepted sample; sampled on each accepted sample.
- `in_valid`, in, 1: new sample present on the interpolator `Din` this cycle.
- `tpo_en`, out, 1: interpolator enable; combinational from registered state and `in_valid`.
- `tpo_mode`, out, 2: interpolator mode; combinational from registered accumulator.
- `out_valid`, out, 1: registered; interpolator `OUT` holds a valid interpolated sample this cycle.
- `skip`, out, 1: registered one-cycle pulse; a sample was dropped on phase wrap.
- `busy`, out, 1: registered; high in FILL or RUN.

## Operation
- States: IDLE, FILL, RUN.
- IDLE:
  - `tpo_en`=0, `tpo_mode`=2, accumulator held at 0, fill counter 0.
  - `start` → FILL.
- FILL:
  - Each `in_valid`: `tpo_en`=1, `tpo_mode`=2, accumulator unchanged, fill counter +1.
  - After `FILL_N` accepted samples → RUN.
  - `out_valid` stays 0.
- RUN, on each `in_valid`:
  - Compute `sum = acc + step` with carry.
  - carry=0: `tpo_en`=1, `acc <= sum[ACC_W-1:0]`, `out_valid` next cycle = 1.
  - carry=1: `tpo_en`=0 (sample dropped), `acc <= sum[ACC_W-1:0]`, `skip` next cycle = 1, `out_valid` next cycle = 0.
- `tpo_mode` in RUN, from `p = acc[ACC_W-1:ACC_W-5]` (current registered value, before update):
  - p 0..5 → mode 0
  - p 6..12 → mode 1
  - p 13..31 → mode 2
- RUN without `in_valid`: `tpo_en`=0, accumulator held, `out_valid`/`skip` next cycle = 0.
- `stop` in any state → IDLE next edge; accumulator and fill counter cleared. `tpo_en` is forced 0 in the `stop` cycle.
- Simultaneous `start` and `stop`: `stop` wins. `start` while busy is ignored.
- `tpo_mode` is never 3; the interpolator hold mode is not used.

## Timing
- Reset (`rst_n`=0 at edge): state IDLE, acc 0, fill counter 0, `out_valid`=0, `skip`=0, `busy`=0. Combinational outputs then give `tpo_en`=0, `tpo_mode`=2.
- Reset mid-RUN behaves exactly as `stop` plus clearing of the registered outputs.
- `start` at edge N: `busy`=1 from N+1; the first sample accepted in FILL is the one with `in_valid` at cycle N+1 or later.
- `tpo_en`/`tpo_mode` settle in the same cycle as `in_valid`; the interpolator latches on that edge.
- `out_valid` and `skip` are asserted one cycle after the accepted/dropped sample, aligned with the interpolator's `OUT` register update.
- Accumulator wrap is modulo 2^ACC_W; `step`=0 never skips; `step`=2^ACC_W-1 skips on all but the first RUN sample.

## Configuration
- `TPO_CTRL_STATS_EN` defined:
  - Adds output `skip_cnt` (out, 16): counts `skip` pulses, saturates at 16'hFFFF.
  - Cleared by reset and on `start`; held in IDLE.
- `TPO_CTRL_STATS_EN` undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset: `rst_n`=0 for 2 cycles, then release with `in_valid`=1 → `tpo_en`=0, `tpo_mode`=2, `busy`/`out_valid`/`skip`=0.
- Prime: `start`, then 2 valid samples with `step`=0 → `tpo_en`=1 both, `out_valid`=0; third sample → `out_valid`=1 one cycle later, `tpo_mode`=0.
- Mode sweep: ACC_W=10, `step`=32 (1/32 per sample) → p steps 0,1,…; mode 0 for p≤5, 1 for 6..12, 2 for 13..31. Wrap after 32 RUN samples → one `skip`, `tpo_en`=0 on that sample.
- Large step: `step`=1023 → RUN samples alternate-free skip on every sample after the first; `out_valid` stays 0 after the first, `skip` pulses each time.
- Abort: `stop` asserted with `start` mid-RUN, with `in_valid`=1 → `tpo_en`=0 that cycle, IDLE next cycle, acc=0. A fresh `start` repeats FILL.
- Stats (`TPO_CTRL_STATS_EN`): `step`=512 for 10 RUN samples → `skip_cnt`=5; `start` clears it to 0.
